// File: rtl/pipe_out_arbiter_if.sv
// pipe_out_arbiter_if
//
// Bundles the host Pipe Out endpoint, both source endpoints and the status
// outputs of pipe_out_arbiter.
//
// Handshake: one host word is transferred on every rising clk edge where
// host_read && host_ready. host_data is valid whenever host_ready is high.
// The granted source sees its srcN_read high on exactly those edges and
// must advance its data word after each one. A host_read while host_ready
// is low moves no data and sets the sticky underrun_err flag.
//
// Modports:
//   master - host/source side: drives host_read, src_en, srcN_ready,
//            srcN_data; observes everything else.
//   slave  - the arbiter.
//
// state_dbg mirrors the arbiter FSM state (0 = ARB, 1 = XFER).
`timescale 1ns/1ps
interface pipe_out_arbiter_if;
    logic        host_read;
    logic [15:0] host_data;
    logic        host_ready;
    logic [1:0]  src_en;
    logic        src0_ready;
    logic [15:0] src0_data;
    logic        src0_read;
    logic        src1_ready;
    logic [15:0] src1_data;
    logic        src1_read;
    logic [1:0]  grant;
    logic [15:0] block_cnt;
    logic        underrun_err;
    logic [15:0] stat0_blocks;
    logic [15:0] stat1_blocks;
    logic        state_dbg;

    modport master (
        output host_read, src_en, src0_ready, src0_data, src1_ready, src1_data,
        input  host_data, host_ready, src0_read, src1_read, grant, block_cnt,
               underrun_err, stat0_blocks, stat1_blocks, state_dbg
    );

    modport slave (
        input  host_read, src_en, src0_ready, src0_data, src1_ready, src1_data,
        output host_data, host_ready, src0_read, src1_read, grant, block_cnt,
               underrun_err, stat0_blocks, stat1_blocks, state_dbg
    );
endinterface

// File: rtl/pipe_out_arbiter.sv
// pipe_out_arbiter
//
// Block-granular round-robin arbiter sharing one host Pipe Out endpoint
// between two data sources. A source is granted for one whole block of
// BLOCK_WORDS words; host reads are steered to it and its data is muxed
// back to the host with no added latency.
//
// Parameters:
//   BLOCK_WORDS  words per granted block (2..65535)
//
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous, active-high reset
//   bus    pipe_out_arbiter_if.slave: host_read/host_data/host_ready,
//          src_en, srcN_ready/srcN_data/srcN_read, grant, block_cnt,
//          underrun_err, stat0_blocks/stat1_blocks, state_dbg
//
// Optional feature macro: PIPE_ARB_STATS_EN
//   defined     - stat0_blocks/stat1_blocks count completed blocks per source
//   not defined - no per-source counters; stat outputs tied to zero
`timescale 1ns/1ps
module pipe_out_arbiter #(
    parameter int BLOCK_WORDS = 512
) (
    input  logic              clk,
    input  logic              reset,
    pipe_out_arbiter_if.slave bus
);

    typedef enum logic {
        ST_ARB  = 1'b0,
        ST_XFER = 1'b1
    } state_t;

    localparam logic [15:0] LAST_IDX = 16'(BLOCK_WORDS - 1);

    state_t      state_q;
    state_t      state_d;
    logic [1:0]  grant_q;
    logic        last_grant_q;   // 0 = source 0 was granted last, 1 = source 1
    logic [15:0] word_cnt_q;
    logic [15:0] block_cnt_q;
    logic        underrun_q;

    logic [1:0]  cand;
    logic [1:0]  pick;
    logic        last_word;

    assign cand      = bus.src_en & {bus.src1_ready, bus.src0_ready};
    assign last_word = (state_q == ST_XFER) && bus.host_read && (word_cnt_q == LAST_IDX);

    // With both sources asking, the one not served last wins.
    always_comb begin
        pick = cand;
        if (cand == 2'b11) begin
            pick = last_grant_q ? 2'b01 : 2'b10;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_ARB;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        if (state_q == ST_ARB) begin
            if (cand != 2'b00) begin
                state_d = ST_XFER;
            end
        end else begin
            if (last_word) begin
                state_d = ST_ARB;
            end
        end
    end

    // Outputs. Reads and data follow the grant register combinationally, so
    // a source sees the host strobe in the same cycle.
    always_comb begin
        bus.host_ready = (state_q == ST_XFER);
        bus.src0_read  = bus.host_read & grant_q[0];
        bus.src1_read  = bus.host_read & grant_q[1];
        case (grant_q)
            2'b01:   bus.host_data = bus.src0_data;
            2'b10:   bus.host_data = bus.src1_data;
            default: bus.host_data = 16'h0000;
        endcase
        bus.grant        = grant_q;
        bus.block_cnt    = block_cnt_q;
        bus.underrun_err = underrun_q;
        bus.state_dbg    = state_q;
    end

    // Grant, word and block bookkeeping. Source ready/enable are only looked
    // at in ARB, so a source dropping out mid-block still finishes its block.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grant_q      <= 2'b00;
            last_grant_q <= 1'b1;
            word_cnt_q   <= 16'h0000;
            block_cnt_q  <= 16'h0000;
            underrun_q   <= 1'b0;
        end else if (state_q == ST_ARB) begin
            if (bus.host_read) begin
                underrun_q <= 1'b1;
            end
            if (cand != 2'b00) begin
                grant_q    <= pick;
                word_cnt_q <= 16'h0000;
            end
        end else if (bus.host_read) begin
            if (word_cnt_q == LAST_IDX) begin
                word_cnt_q   <= 16'h0000;
                grant_q      <= 2'b00;
                last_grant_q <= grant_q[1];
                block_cnt_q  <= block_cnt_q + 16'd1;
            end else begin
                word_cnt_q <= word_cnt_q + 16'd1;
            end
        end
    end

`ifdef PIPE_ARB_STATS_EN
    logic [15:0] stat0_q;
    logic [15:0] stat1_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat0_q <= 16'h0000;
            stat1_q <= 16'h0000;
        end else if (last_word) begin
            if (grant_q[0]) begin
                stat0_q <= stat0_q + 16'd1;
            end
            if (grant_q[1]) begin
                stat1_q <= stat1_q + 16'd1;
            end
        end
    end

    assign bus.stat0_blocks = stat0_q;
    assign bus.stat1_blocks = stat1_q;
`else
    assign bus.stat0_blocks = 16'h0000;
    assign bus.stat1_blocks = 16'h0000;
`endif

endmodule

// File: doc/pipe_out_arbiter.md
# pipe_out_arbiter

Block-granular round-robin arbiter that shares one host Pipe Out endpoint between two pseudorandom/count data sources (each with the read/data/ready interface of the Pipe Out check generator). It grants the host one whole block at a time from a source that reports a block available, steers host read strobes to that source and muxes its data back. Sits between the host interface and the two source instances in the PipeTest design.

## Interface
- BLOCK_WORDS, 512, 16-bit words per granted block; legal range 2..65535.
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- host_read  in  1  host read strobe; one word consumed per cycle high.
- host_data  out  16  word returned to host.
- host_ready  out  1  a granted block is in progress and readable.
- src_en  in  2  per-source enable; bit n enables source n for arbitration.
- src0_ready  in  1  source 0 has at least one block available.
- src0_data  in  16  source 0 data.
- src0_read  out  1  read strobe to source 0.
- src1_ready, src1_data, src1_read  same as source 0, for source 1.
- grant  out  2  one-hot current grant; 2'b00 when none.
- block_cnt  out  16  total completed blocks, wraps 65535 -> 0.
- underrun_err  out  1  sticky: host_read seen while host_ready low.
- stat0_blocks, stat1_blocks  out  16  per-source completed blocks (see Configuration).

## Operation
- States: ARB, XFER.
- ARB: candidate n = src_en[n] & srcn_ready. If none, stay. If one, grant it. If both, grant the source that is not last_grant. On grant: grant register set, word_cnt = 0, next state XFER.
- XFER: src_read[n] = host_read & grant[n] (combinational); non-granted source read held 0. Each host_read cycle increments word_cnt.
- Read with word_cnt == BLOCK_WORDS-1: word_cnt -> 0, last_grant <= granted source, grant -> 2'b00, block_cnt += 1, next state ARB.
- Mid-block changes ignored: granted source dropping srcn_ready or src_en does not abort the block; the source threshold guarantees a full block.
- host_data = granted source data; 16'h0000 when grant == 2'b00.
- host_read in ARB: no source read, word_cnt unchanged, underrun_err set; cleared only by reset.
- Reset values: state ARB, grant 2'b00, last_grant = source 1 (so source 0 wins first tie), word_cnt 0, host_ready 0, host_data 0, src reads 0, block_cnt 0, underrun_err 0, stats 0.
- word_cnt 16 bits; block counters wrap modulo 2^16 silently.

## Timing
- host_ready = (state == XFER), registered; rises one cycle after the ARB cycle that sees a candidate.
- Arbitration latency: 1 cycle ARB -> XFER; minimum inter-block gap is 1 cycle in ARB (host_ready low for exactly one cycle when the next candidate is already ready).
- host_ready falls in the cycle after the edge that consumes the last word.
- src_read and host_data are combinational from grant; zero added latency over the source.
- Reset asserted mid-block: all state cleared immediately (asynchronous); partial block discarded, not counted.
- Source 0 and 1 both ready with src_en = 2'b11 continuously: grants strictly alternate 0,1,0,1.

## Configuration
- PIPE_ARB_STATS_EN defined: stat0_blocks/stat1_blocks count completed blocks per source, incremented in the same cycle as block_cnt, wrap at 2^16.
- Not defined: counters not built; stat0_blocks and stat1_blocks tied to 16'h0000. block_cnt and all other behaviour unchanged.

## Test plan
- Reset, src_en=2'b11, both ready, BLOCK_WORDS=4, host_read held high -> grants 01,10,01,10; host_ready high 4 cycles, low 1; block_cnt=4 after 20 cycles.
- Only src1 ready, src_en=2'b11 -> grant 10 every block; src0_read never asserted; stat1_blocks==block_cnt with PIPE_ARB_STATS_EN.
- src0 granted, drop src0_ready and src_en[0] after word 1 -> block completes all 4 words, then src1 granted.
- host_read pulsed while grant==00 -> underrun_err=1, no src read, word_cnt 0; stays 1 until reset.
- Assert reset after word 2 of a block -> host_ready, grant, block_cnt, word_cnt 0 same cycle; next block from source 0 starts at word_cnt 0.
- Preload block_cnt to 65535 via 65535 blocks (or force), complete one block -> block_cnt 0, no other side effect.
